and_reduce_pipe: RTL and testbench
==================================

# and_reduce_pipe

Parametrised, pipelined, masked AND-reduction of a WIDTH-bit word to a single bit, built as a tree of FANIN-input AND stages with one register level per tree level. Used by the adder datapath for wide group-propagate and zero-detect terms that are too deep for a single combinational gate. Transactions flow under a valid/ready handshake with full back-pressure; one result per cycle at full throughput.

## Interface
- `WIDTH`, default 32: input word width, 2..256.
- `FANIN`, default 4: AND inputs per tree node, 2..5.
- `STAGES`, derived, not overridable: ceil(log_FANIN(WIDTH)), minimum 1. WIDTH=32/FANIN=4 gives 3.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: block accepts the word this cycle.
- `in_data` in WIDTH: operand bits.
- `in_mask` in WIDTH: 1 = bit participates; 0 = bit forced to 1 (don't care).
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_result` out 1: AND over all bits of (in_data | ~in_mask).
- `out_zidx` out clog2(WIDTH): present only with AND_REDUCE_PIPE_ZIDX_EN; see Configuration.

## Operation
- Level 0 input: `e = in_data | ~in_mask`, padded with 1s up to FANIN^STAGES bits.
- Level k register holds ceil(WIDTH/FANIN^(k+1)) partial ANDs plus a valid bit; last level is the single output register.
- Empty mask (in_mask all 0) yields out_result = 1.
- Elastic pipeline: stage k loads when stage k is empty or stage k+1 (or the consumer, for the last stage) takes its contents this cycle. in_ready = stage-0 load condition.
- Capacity: STAGES transactions in flight; order preserved; no loss, no duplication.
- ready path is combinational from out_ready back to in_ready; data/valid paths are fully registered.
- Unused transfer: in_valid=0 while stage loads clears that stage's valid bit (bubble).

## Timing
- Latency: word accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles from in_valid&in_ready to out_valid, when downstream never stalls.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 holds out_result/out_zidx stable until taken; upstream stages fill in order; in_ready falls once all STAGES registers are valid.
- Simultaneous take and load in the same stage is permitted (full throughput while stalled-then-released).
- Reset values: all stage valid bits 0, out_valid 0, out_result 0, out_zidx 0; in_ready 1 one cycle after rst_n deasserts is not required — in_ready is 1 as soon as reset is released (pipeline empty).
- Reset mid-operation: all in-flight transactions discarded immediately (asynchronous); no partial result emitted.
- in_data/in_mask ignored when in_valid=0 or in_ready=0.

## Configuration
- Macro `AND_REDUCE_PIPE_ZIDX_EN`.
- Defined: port out_zidx exists; each tree node carries the lowest participating zero index among its children alongside the AND bit; out_zidx = index of the lowest bit with in_data=0 and in_mask=1; 0 when out_result=1. Same latency and handshake.
- Undefined: no out_zidx port, no index registers; result path identical.

## Structure
- Package `and_pkg`: clog2 function, stages-count function (ceil log base FANIN), padded-width constant helper, FANIN range constants.
- Sub-module `and_reduce_stage`: one tree level — registered FANIN-way AND of each input group, valid bit, load/take logic, optional index carry under the macro. Top level instantiates STAGES of them via generate.

## Test plan
- WIDTH=32, FANIN=4: in_data=0xFFFF_FFFF, in_mask=0xFFFF_FFFF, one-cycle valid, out_ready=1 -> out_valid after 3 cycles, out_result=1, out_zidx=0.
- in_data=0xFFFF_FEFF, mask all 1 -> out_result=0, out_zidx=8; same data with in_mask=0xFFFF_FEFF -> out_result=1.
- in_data=0x0000_0000, in_mask=0 -> out_result=1.
- 8 back-to-back words, out_ready=0 after the first 2 results -> in_ready drops after 3 more accepted, out_result stable; out_ready=1 -> remaining results in order, none lost or duplicated.
- rst_n low with 3 words in flight -> out_valid=0 immediately; after release in_ready=1, no stale output appears.
- WIDTH=5, FANIN=2 (3 stages, padding): 5'b11111 -> 1; 5'b01111 -> 0 with out_zidx=4.

Source files
------------

// File: rtl/and_reduce_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined AND-reduction tree.
package and_pkg;

  localparam int unsigned FANIN_MIN = 2;
  localparam int unsigned FANIN_MAX = 5;
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 256;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Number of tree nodes feeding level k (k=0 is the raw word).
  function automatic int unsigned level_count(input int unsigned w, input int unsigned f,
                                              input int unsigned k);
    int unsigned n;
    n = w;
    for (int unsigned i = 0; i < k; i++) n = (n + f - 1) / f;
    return n;
  endfunction

  function automatic int unsigned stages_count(input int unsigned w, input int unsigned f);
    int unsigned s;
    int unsigned n;
    s = 0;
    n = w;
    while (n > 1) begin
      n = (n + f - 1) / f;
      s++;
    end
    if (s == 0) s = 1;
    return s;
  endfunction

  function automatic int unsigned padded_width(input int unsigned w, input int unsigned f);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < stages_count(w, f); i++) p = p * f;
    return p;
  endfunction

endpackage

// File: rtl/and_reduce_pipe_stage.sv
// One elastic tree level: registered FANIN-way AND per group, valid bit, load/take control.
// Optional lowest-zero index carry under AND_REDUCE_PIPE_ZIDX_EN.
module and_reduce_stage
  import and_pkg::*;
#(
  parameter int unsigned IN_N  = 32,
  parameter int unsigned FANIN = 4
`ifdef AND_REDUCE_PIPE_ZIDX_EN
  ,
  parameter int unsigned IDXW  = 5
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_N-1:0]                       in_bits,
  output logic                                  out_valid,
  input  logic                                  out_take,
  output logic [(IN_N+FANIN-1)/FANIN-1:0]       out_bits
`ifdef AND_REDUCE_PIPE_ZIDX_EN
  ,
  input  logic [IN_N*IDXW-1:0]                  in_idx,
  output logic [((IN_N+FANIN-1)/FANIN)*IDXW-1:0] out_idx
`endif
);

  localparam int unsigned OUT_N = (IN_N + FANIN - 1) / FANIN;

  logic [OUT_N*FANIN-1:0] pad_bits;
  logic [OUT_N-1:0]       and_d;
  logic [OUT_N-1:0]       bits_d, bits_q;
  logic                   valid_d, valid_q;
  logic                   load;

`ifdef AND_REDUCE_PIPE_ZIDX_EN
  logic [OUT_N*FANIN*IDXW-1:0] pad_idx;
  logic [OUT_N*IDXW-1:0]       idx_and;
  logic [OUT_N*IDXW-1:0]       idx_d, idx_q;
`endif

  assign load     = !valid_q || out_take;
  assign in_ready = load;

  // Missing children of the last group are padded with 1s so they never win.
  always_comb begin
    pad_bits = '1;
    pad_bits[IN_N-1:0] = in_bits;
    and_d = '1;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
    pad_idx = '0;
    pad_idx[IN_N*IDXW-1:0] = in_idx;
    idx_and = '0;
`endif
    for (int unsigned g = 0; g < OUT_N; g++) begin
      for (int unsigned c = 0; c < FANIN; c++) begin
`ifdef AND_REDUCE_PIPE_ZIDX_EN
        if (and_d[g] && !pad_bits[g*FANIN+c])
          idx_and[g*IDXW +: IDXW] = pad_idx[(g*FANIN+c)*IDXW +: IDXW];
`endif
        and_d[g] = and_d[g] & pad_bits[g*FANIN+c];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
    idx_d   = idx_q;
`endif
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        bits_d = and_d;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
        idx_d  = idx_and;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
      idx_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_bits  = bits_q;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
  assign out_idx   = idx_q;
`endif

endmodule

// File: rtl/and_reduce_pipe.sv
// Pipelined masked AND-reduction tree with valid/ready back-pressure.
// Define AND_REDUCE_PIPE_ZIDX_EN to add out_zidx (lowest participating zero bit).
module and_reduce_pipe
  import and_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FANIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result
`ifdef AND_REDUCE_PIPE_ZIDX_EN
  ,
  output logic [clog2(WIDTH)-1:0] out_zidx
`endif
);

  localparam int unsigned STAGES = stages_count(WIDTH, FANIN);

  logic [WIDTH-1:0] lvl_bits [STAGES+1];
  logic [STAGES:0]  lvl_vld;
  logic [STAGES:0]  lvl_rdy;

  assign lvl_bits[0]     = in_data | ~in_mask;
  assign lvl_vld[0]      = in_valid;
  assign in_ready        = lvl_rdy[0];
  assign lvl_rdy[STAGES] = out_ready;
  assign out_valid       = lvl_vld[STAGES];
  assign out_result      = lvl_bits[STAGES][0];

`ifdef AND_REDUCE_PIPE_ZIDX_EN
  localparam int unsigned IDXW = clog2(WIDTH);

  logic [WIDTH*IDXW-1:0] lvl_idx [STAGES+1];
  logic [WIDTH*IDXW-1:0] leaf_idx;

  always_comb begin
    leaf_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) leaf_idx[i*IDXW +: IDXW] = IDXW'(i);
  end

  assign lvl_idx[0] = leaf_idx;
  assign out_zidx   = lvl_idx[STAGES][IDXW-1:0];
`endif

  // Each level occupies the low end of a WIDTH-wide bus; the unused top is tied off.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IN_N  = level_count(WIDTH, FANIN, k);
    localparam int unsigned OUT_N = level_count(WIDTH, FANIN, k + 1);

    and_reduce_stage #(
      .IN_N  (IN_N),
      .FANIN (FANIN)
`ifdef AND_REDUCE_PIPE_ZIDX_EN
      ,
      .IDXW  (IDXW)
`endif
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (lvl_vld[k]),
      .in_ready  (lvl_rdy[k]),
      .in_bits   (lvl_bits[k][IN_N-1:0]),
      .out_valid (lvl_vld[k+1]),
      .out_take  (lvl_rdy[k+1]),
      .out_bits  (lvl_bits[k+1][OUT_N-1:0])
`ifdef AND_REDUCE_PIPE_ZIDX_EN
      ,
      .in_idx    (lvl_idx[k][IN_N*IDXW-1:0]),
      .out_idx   (lvl_idx[k+1][OUT_N*IDXW-1:0])
`endif
    );

    if (OUT_N < WIDTH) begin : g_fill
      assign lvl_bits[k+1][WIDTH-1:OUT_N] = '1;
`ifdef AND_REDUCE_PIPE_ZIDX_EN
      assign lvl_idx[k+1][WIDTH*IDXW-1:OUT_N*IDXW] = '0;
`endif
    end
  end

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Scoreboard bench for and_reduce_pipe at 32/4 and 5/2 (padded tree).
module tb_and_reduce_pipe;

  typedef struct {
    logic       r;
    logic [4:0] z;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        v1, r1, ov1, or1, res1;
  logic [31:0] d1, m1;
  logic [4:0]  z1;

  logic        v2, r2, ov2, or2, res2;
  logic [4:0]  d2, m2;
  logic [2:0]  z2;

  int errors = 0;
  int checks = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  and_reduce_pipe #(.WIDTH(32), .FANIN(4)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v1),
    .in_ready   (r1),
    .in_data    (d1),
    .in_mask    (m1),
    .out_valid  (ov1),
    .out_ready  (or1),
    .out_result (res1)
`ifdef AND_REDUCE_PIPE_ZIDX_EN
    ,
    .out_zidx   (z1)
`endif
  );

  and_reduce_pipe #(.WIDTH(5), .FANIN(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v2),
    .in_ready   (r2),
    .in_data    (d2),
    .in_mask    (m2),
    .out_valid  (ov2),
    .out_ready  (or2),
    .out_result (res2)
`ifdef AND_REDUCE_PIPE_ZIDX_EN
    ,
    .out_zidx   (z2)
`endif
  );

`ifndef AND_REDUCE_PIPE_ZIDX_EN
  assign z1 = '0;
  assign z2 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] d, input logic [31:0] m, input int w);
    exp_t e;
    e.r = 1'b1;
    e.z = '0;
    for (int i = w - 1; i >= 0; i--) begin
      if (m[i] && !d[i]) begin
        e.r = 1'b0;
        e.z = i[4:0];
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      chk("dut1 output expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("dut1 out_result", 32'(res1), 32'(e1.r));
`ifdef AND_REDUCE_PIPE_ZIDX_EN
        chk("dut1 out_zidx", 32'(z1), 32'(e1.z));
`endif
      end
    end
    if (rst_n && ov2 && or2) begin
      chk("dut2 output expected", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("dut2 out_result", 32'(res2), 32'(e2.r));
`ifdef AND_REDUCE_PIPE_ZIDX_EN
        chk("dut2 out_zidx", 32'(z2), 32'(e2.z));
`endif
      end
    end
  end

  task automatic send1(input logic [31:0] d, input logic [31:0] m);
    int n;
    n = 0;
    v1 = 1'b1;
    d1 = d;
    m1 = m;
    @(negedge clk);
    while (!r1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut1 accept", 32'(r1), 32'd1);
    if (r1) q1.push_back(model(d, m, 32));
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [4:0] d, input logic [4:0] m);
    int n;
    n = 0;
    v2 = 1'b1;
    d2 = d;
    m2 = m;
    @(negedge clk);
    while (!r2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut2 accept", 32'(r2), 32'd1);
    if (r2) q2.push_back(model({27'd0, d}, {27'd0, m}, 5));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain queues empty", 32'(q1.size() + q2.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stall_word(input int i);
    logic [31:0] one;
    one = 32'h1;
    return (i % 2 == 1) ? ~(one << (i * 3)) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; d1 = '0; m1 = '0; or1 = 1'b1;
    v2 = 1'b0; d2 = '0; m2 = '0; or2 = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset dut1 out_valid", 32'(ov1), 32'd0);
    chk("reset dut1 out_result", 32'(res1), 32'd0);
    chk("reset dut1 out_zidx", 32'(z1), 32'd0);
    chk("reset dut2 out_valid", 32'(ov2), 32'd0);
    chk("reset dut2 out_result", 32'(res2), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release dut1 in_ready", 32'(r1), 32'd1);
    chk("release dut2 in_ready", 32'(r2), 32'd1);
    @(posedge clk);
    #1;

    // Latency: single word, out_valid two edges after the accepting edge.
    send1(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    v1 = 1'b0;
    @(posedge clk);
    #1;
    chk("latency out_valid early", 32'(ov1), 32'd0);
    @(posedge clk);
    #1;
    chk("latency out_valid", 32'(ov1), 32'd1);
    drain();

    send1(32'hFFFF_FEFF, 32'hFFFF_FFFF);
    send1(32'hFFFF_FEFF, 32'hFFFF_FEFF);
    send1(32'h0000_0000, 32'h0000_0000);
    send1(32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) send1($urandom, $urandom);
    v1 = 1'b0;
    drain();

    // Back-pressure: stall after two results, pipeline fills with three more.
    for (int i = 0; i < 5; i++) send1(stall_word(i), 32'hFFFF_FFFF);
    or1 = 1'b0;
    v1 = 1'b1;
    d1 = stall_word(5);
    m1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall in_ready", 32'(r1), 32'd0);
      chk("stall out_valid", 32'(ov1), 32'd1);
      chk("stall out_result", 32'(res1), 32'(q1[0].r));
      chk("stall in flight", 32'(q1.size()), 32'd3);
    end
    @(posedge clk);
    #1;
    or1 = 1'b1;
    for (int i = 5; i < 8; i++) send1(stall_word(i), 32'hFFFF_FFFF);
    v1 = 1'b0;
    drain();

    // Padded 5-bit tree.
    send2(5'b11111, 5'b11111);
    send2(5'b01111, 5'b11111);
    send2(5'b10110, 5'b11111);
    send2(5'b00000, 5'b00000);
    send2(5'b01111, 5'b01111);
    v2 = 1'b0;
    drain();

    // Asynchronous reset with three words in flight.
    or1 = 1'b0;
    for (int i = 0; i < 3; i++) send1(32'h0000_00F0, 32'hFFFF_FFFF);
    v1 = 1'b0;
    chk("pre-reset out_valid", 32'(ov1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(ov1), 32'd0);
    chk("async reset out_result", 32'(res1), 32'd0);
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    or1 = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(r1), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post-reset no stale out_valid", 32'(ov1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
